// File: rtl/order_entry.sv
// order_entry: operator order writer. Debounces the three board keys, latches
// switch values as buy/sell prices clamped to 0..MAX_PRICE, and offers one
// order at a time downstream over a valid/ready handshake.
// Optional build macro ORDER_CHECK_EN: when defined, a submit is rejected
// (entry_err pulse) unless both prices have been loaded since the last order.
module order_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_PRICE       = 99
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] sw_value,
    input  logic       key_buy_n,
    input  logic       key_sell_n,
    input  logic       key_submit_n,
    input  logic       order_ready,
    output logic       order_valid,
    output logic [7:0] buy_price,
    output logic [7:0] sell_price,
    output logic [1:0] state,
    output logic [7:0] order_count,
    output logic       entry_err
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [7:0]     MAX_P   = 8'(MAX_PRICE);

    // Key index order inside the debounce arrays.
    localparam int K_BUY    = 0;
    localparam int K_SELL   = 1;
    localparam int K_SUBMIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01
    } state_t;

    // Saturate a switch value to the displayable price range.
    function automatic logic [7:0] clamp_price(input logic [7:0] v);
        logic [7:0] r;
        if (v > MAX_P) begin
            r = MAX_P;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [2:0]    keys_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    level_r;
    logic [2:0]    press_r;
    logic [CW-1:0] cnt_r [0:2];

    state_t        state_r;
    logic          valid_r;
    logic [7:0]    buy_price_r;
    logic [7:0]    sell_price_r;
    logic [7:0]    order_count_r;
    logic          err_r;
    logic          buy_loaded_r;
    logic          sell_loaded_r;

    logic          buy_ev_s;
    logic          sell_ev_s;
    logic          submit_ev_s;
    logic          accept_s;
    logic [7:0]    clamped_s;

    assign keys_s      = {key_submit_n, key_sell_n, key_buy_n};
    assign buy_ev_s    = press_r[K_BUY];
    assign sell_ev_s   = press_r[K_SELL];
    assign submit_ev_s = press_r[K_SUBMIT];
    assign clamped_s   = clamp_price(sw_value);

    // Decide whether a submit in IDLE may become an order; a load in the
    // same cycle counts, since that load is applied on the same edge.
    always_comb begin
        accept_s = 1'b1;
`ifdef ORDER_CHECK_EN
        accept_s = (buy_loaded_r | buy_ev_s) & (sell_loaded_r | sell_ev_s);
`else
        accept_s = 1'b1;
`endif
    end

    // Synchronize each raw key, debounce its level, and pulse on press only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
            level_r <= 3'b111;
            press_r <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                sync1_r[k] <= keys_s[k];
                sync2_r[k] <= sync1_r[k];
                press_r[k] <= 1'b0;
                if (sync2_r[k] == level_r[k]) begin
                    cnt_r[k] <= '0;
                end else if (cnt_r[k] == CNT_MAX) begin
                    // Level flips; only the released-to-pressed flip is an event.
                    level_r[k] <= sync2_r[k];
                    cnt_r[k]   <= '0;
                    press_r[k] <= level_r[k];
                end else begin
                    cnt_r[k] <= cnt_r[k] + CW'(1);
                end
            end
        end
    end

    // Order FSM with price registers, loaded flags and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            valid_r       <= 1'b0;
            buy_price_r   <= 8'd0;
            sell_price_r  <= 8'd0;
            order_count_r <= 8'd0;
            err_r         <= 1'b0;
            buy_loaded_r  <= 1'b0;
            sell_loaded_r <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (buy_ev_s) begin
                        buy_price_r  <= clamped_s;
                        buy_loaded_r <= 1'b1;
                    end
                    if (sell_ev_s) begin
                        sell_price_r  <= clamped_s;
                        sell_loaded_r <= 1'b1;
                    end
                    if (submit_ev_s) begin
                        if (accept_s) begin
                            state_r <= ST_PEND;
                            valid_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    // Prices are frozen here; loads and submits are ignored.
                    if (valid_r && order_ready) begin
                        state_r       <= ST_IDLE;
                        valid_r       <= 1'b0;
                        order_count_r <= order_count_r + 8'd1;
                        buy_loaded_r  <= 1'b0;
                        sell_loaded_r <= 1'b0;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign order_valid = valid_r;
    assign buy_price   = buy_price_r;
    assign sell_price  = sell_price_r;
    assign state       = state_r;
    assign order_count = order_count_r;
    assign entry_err   = err_r;

endmodule

// File: doc/order_entry.md
Name: order_entry

Overview:
- Operator-side order writer for the trading datapath: debounces board keys, latches switch values as buy/sell prices, and issues an order to the matching engine with a valid/ready handshake.
- Produces the buy_price/sell_price/state values consumed by the HEX/LEDR display block, so it is the input end of the same price interface.
- Prices are clamped to 0..99 so every value is displayable as two decimal digits.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- MAX_PRICE, 99, saturation ceiling applied to latched prices.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- sw_value  in  8  price value from switches, unsigned.
- key_buy_n  in  1  raw active-low buy-load key, asynchronous to clk.
- key_sell_n  in  1  raw active-low sell-load key, asynchronous to clk.
- key_submit_n  in  1  raw active-low submit key, asynchronous to clk.
- order_ready  in  1  downstream accepts the order when high with order_valid.
- order_valid  out  1  order offered downstream.
- buy_price  out  8  latched buy price, 0..MAX_PRICE.
- sell_price  out  8  latched sell price, 0..MAX_PRICE.
- state  out  2  FSM state for LEDR: 00 IDLE, 01 PEND.
- order_count  out  8  accepted orders, modulo 256.
- entry_err  out  1  one-cycle pulse on a rejected submit.

Behaviour:
- Reset, asynchronous: outputs buy_price=0, sell_price=0, order_valid=0, state=IDLE, order_count=0, entry_err=0. Synchronizers, debounce counters and loaded flags clear. Assertion mid-handshake drops order_valid immediately.
- Key path, per key:
  - 2-flop synchronizer feeds a debounce counter.
  - The counter resets whenever the synchronized level equals the debounced level. Otherwise it increments.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A press event is a 1-cycle pulse on the debounced high-to-low flip only. Release generates no event.
  - Latency from the first clk edge sampling a stable low raw key to the register update is exactly DEBOUNCE_CYCLES+3 edges.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Loading, IDLE only:
  - A buy event loads buy_price = min(sw_value, MAX_PRICE) and sets buy_loaded.
  - A sell event loads sell_price = min(sw_value, MAX_PRICE) and sets sell_loaded.
  - Simultaneous buy and sell events load both registers from the same sw_value.
  - Load events in PEND are ignored.
- FSM:
  - IDLE -> PEND on a submit event.
  - order_valid=1 during PEND.
  - If a load and a submit event occur in the same cycle, the load applies and the offered order carries the new value. order_valid and the new price appear on the same edge.
  - PEND -> IDLE on the edge where order_valid && order_ready. On that edge: order_count increments (255 wraps to 0), order_valid clears, and buy_loaded/sell_loaded clear.
  - If order_ready is already high, order_valid lasts exactly 1 cycle.
- Stability: buy_price and sell_price are constant while order_valid=1.
- Submit events in PEND are ignored, with no error pulse.

Optional Feature:
- Macro ORDER_CHECK_EN.
- Defined:
  - A submit event in IDLE while !(buy_loaded && sell_loaded) is rejected.
  - On rejection: state stays IDLE, order_valid stays 0, and entry_err pulses high for exactly 1 cycle on the following edge.
- Undefined:
  - Submit is always accepted and stale or reset prices are reused.
  - entry_err is tied 0.

Test Plan (DEBOUNCE_CYCLES=4):
1. sw_value=37, hold key_buy_n low 10 cycles -> buy_price=37 exactly 7 edges after first low sample. A 3-cycle low glitch on key_sell_n -> sell_price unchanged.
2. sw_value=150, press sell -> sell_price=99. sw_value=99 -> 99. sw_value=0 -> 0.
3. Load buy=50, sell=45, order_ready=0, press submit -> order_valid=1, state=01, prices held for 20 cycles while sw_value and buy/sell keys toggle. Raise order_ready -> valid falls next edge, order_count=1, state=00.
4. order_ready tied 1, 256 load-load-submit sequences -> order_valid is a 1-cycle pulse each time and order_count wraps to 0.
5. Assert resetn=0 during PEND -> order_valid, prices, and order_count go to 0 without a clock edge.
6. ORDER_CHECK_EN defined, only buy loaded, press submit -> entry_err 1-cycle pulse, order_valid stays 0. Without the macro -> order offered with sell_price=0.
